// File: rtl/sasl2_session_ctrl.sv
// sasl2_session_ctrl: sequences one SAS-L2 authentication exchange.
// It takes alpha in, calls the core, streams beta out, then commits or retries on the verdict.
module sasl2_session_ctrl #(
   parameter int TIMEOUT = 1024,
   parameter int MAX_RETRY = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [31:0]  rx_data,
   input  logic         rx_valid,
   output logic         rx_ready,
   output logic [31:0]  tx_data,
   output logic         tx_valid,
   input  logic         tx_ready,
   input  logic         verd_valid,
   input  logic         verd_ok,
   output logic [255:0] core_alpha,
   output logic         core_call,
   output logic         core_suc,
   input  logic [255:0] core_beta,
   input  logic         core_done,
   output logic         busy,
   output logic         pass,
   output logic         fail,
   output logic [2:0]   st
);
   localparam int TW = $clog2(TIMEOUT) + 1;
   localparam int RW = $clog2(MAX_RETRY + 1);
   typedef enum logic [2:0] {
      IDLE = 3'd0, RX_ALPHA = 3'd1, CALL = 3'd2, WAIT_CORE = 3'd3,
      TX_BETA = 3'd4, WAIT_VERD = 3'd5, COMMIT = 3'd6, ABORT = 3'd7
   } state_t;
   state_t         state;
   logic [2:0]     word_idx;
   logic [RW-1:0]  retry_cnt;
   logic [RW-1:0]  retry_nx;
   logic [TW-1:0]  tcnt;
   logic [255:0]   beta;
   logic           expire;
   assign expire    = tcnt == TW'(TIMEOUT - 1);
   assign retry_nx  = retry_cnt + RW'(1);
   assign st        = state;
   assign busy      = state != IDLE;
   assign rx_ready  = state == RX_ALPHA;
   assign tx_valid  = state == TX_BETA;
   assign core_call = state == CALL;
   assign core_suc  = state == COMMIT;
   assign pass      = state == COMMIT;
   assign fail      = state == ABORT;
   assign tx_data   = beta[{word_idx, 5'd0} +: 32];
   // tcnt falls back to zero unless a waiting state explicitly advances it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         word_idx   <= '0;
         retry_cnt  <= '0;
         tcnt       <= '0;
         core_alpha <= '0;
         beta       <= '0;
      end else begin
         tcnt <= '0;
         case (state)
            IDLE:
               if (start) begin
                  state     <= RX_ALPHA;
                  word_idx  <= '0;
                  retry_cnt <= '0;
               end
            RX_ALPHA:
               if (rx_valid) begin
                  core_alpha[{word_idx, 5'd0} +: 32] <= rx_data;
                  word_idx <= word_idx + 3'd1;
                  if (word_idx == 3'd7) state <= CALL;
               end else if (expire) state <= ABORT;
               else tcnt <= tcnt + TW'(1);
            CALL: state <= WAIT_CORE;
            WAIT_CORE:
               if (core_done) begin
                  beta  <= core_beta;
                  state <= TX_BETA;
               end else if (expire) state <= ABORT;
               else tcnt <= tcnt + TW'(1);
            TX_BETA:
               if (tx_ready) begin
                  word_idx <= word_idx + 3'd1;
                  if (word_idx == 3'd7) state <= WAIT_VERD;
               end else if (expire) state <= ABORT;
               else tcnt <= tcnt + TW'(1);
            WAIT_VERD:
               if (verd_valid) begin
                  if (verd_ok) state <= COMMIT;
                  else begin
                     retry_cnt <= retry_nx;
                     word_idx  <= '0;
                     state     <= (retry_nx < RW'(MAX_RETRY)) ? RX_ALPHA : ABORT;
                  end
               end else if (expire) state <= ABORT;
               else tcnt <= tcnt + TW'(1);
            COMMIT: state <= IDLE;
            ABORT: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sasl2_session_ctrl.sv
// tb_sasl2_session_ctrl: table of whole sessions plus timeout and mid-session reset sequences.
module tb_sasl2_session_ctrl;
   localparam int TO = 16;
   localparam int MR = 3;
   logic clk = 0, rst_n = 0, start = 0, rx_valid = 0, tx_ready = 0;
   logic verd_valid = 0, verd_ok = 0, core_done = 0;
   logic [31:0] rx_data = '0;
   logic [255:0] core_beta = '0;
   logic rx_ready, tx_valid, core_call, core_suc, busy, pass, fail;
   logic [31:0] tx_data;
   logic [255:0] core_alpha;
   logic [2:0] st;
   always #5 clk = ~clk;
   sasl2_session_ctrl #(.TIMEOUT(TO), .MAX_RETRY(MR)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_ready(rx_ready), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .verd_valid(verd_valid), .verd_ok(verd_ok), .core_alpha(core_alpha),
      .core_call(core_call), .core_suc(core_suc), .core_beta(core_beta),
      .core_done(core_done), .busy(busy), .pass(pass), .fail(fail), .st(st)
   );
   int checks = 0, failures = 0;
   int n_call = 0, n_suc = 0, n_pass = 0, n_fail = 0, stall_bad = 0;
   logic prev_stall = 0;
   logic [31:0] prev_data = '0;
   always @(negedge clk) begin
      n_call <= n_call + int'(core_call);
      n_suc  <= n_suc + int'(core_suc);
      n_pass <= n_pass + int'(pass);
      n_fail <= n_fail + int'(fail);
      if (prev_stall && tx_valid && tx_data != prev_data) stall_bad <= stall_bad + 1;
      prev_stall <= tx_valid && !tx_ready;
      prev_data  <= tx_data;
   end
   typedef struct {
      int nfail;
      int gap;
      int exp_pass;
      int exp_fail;
      int exp_calls;
      int exp_suc;
   } vec_t;
   vec_t tbl[5];
   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   function automatic logic [31:0] aw(input int a, input int k);
      return (32'h11111111 * 32'(k + 1)) ^ (32'(a) << 24);
   endfunction
   function automatic logic [31:0] bw(input int r, input int a, input int k);
      return (r == 0) ? 32'hA5A5A5A5 : (32'hB0000000 | (32'(r) << 16) | (32'(a) << 8) | 32'(k));
   endfunction
   task automatic send_alpha(input int a, input int nw, input int gap, output int cyc);
      int i;
      logic xf;
      i = 0;
      cyc = 0;
      while (i < nw && cyc < 64) begin
         rx_valid = gap != 0 ? (cyc % 2 == 1) : 1'b1;
         rx_data = aw(a, i);
         xf = rx_valid && rx_ready;
         tick();
         if (xf) i++;
         cyc++;
      end
      rx_valid = 0;
      if (i != nw) check("rx_words_timeout", 256'(i), 256'(nw));
   endtask
   task automatic run_row(input int r);
      vec_t v;
      logic [255:0] ea, eb, got;
      int a, j, cyc, c_call, c_suc, c_pass, c_fail;
      bit done;
      v = tbl[r];
      c_call = n_call; c_suc = n_suc; c_pass = n_pass; c_fail = n_fail;
      a = 0;
      done = 0;
      check("idle_st", 256'(st), 0);
      start = 1; tick(); start = 0;
      while (!done) begin
         for (int k = 0; k < 8; k++) begin
            ea[k*32 +: 32] = aw(a, k);
            eb[k*32 +: 32] = bw(r, a, k);
         end
         send_alpha(a, 8, v.gap, cyc);
         if (v.gap == 0) check("rx_cycles", 256'(cyc), 8);
         check("core_call", 256'(core_call), 1);
         check("core_alpha", core_alpha, ea);
         repeat (5) tick();
         core_done = 1; core_beta = eb;
         tick();
         core_done = 0;
         check("tx_valid_after_done", 256'(tx_valid), 1);
         j = 0; cyc = 0; got = '0;
         while (j < 8 && cyc < 64) begin
            tx_ready = v.gap != 0 ? (cyc % 2 == 1) : 1'b1;
            if (tx_valid && tx_ready) begin
               got[j*32 +: 32] = tx_data;
               j++;
            end
            tick();
            cyc++;
         end
         tx_ready = 0;
         check("beta_words", got, eb);
         check("st_wait_verd", 256'(st), 5);
         verd_valid = 1; verd_ok = (a == v.nfail);
         tick();
         verd_valid = 0; verd_ok = 0;
         if (a == v.nfail) begin
            check("commit_st", 256'(st), 6);
            check("commit_pulses", {core_suc, pass, fail}, 3'b110);
            done = 1;
         end else if (a + 1 < MR) begin
            check("retry_st", 256'(st), 1);
         end else begin
            check("abort_st", 256'(st), 7);
            check("abort_pulses", {core_suc, pass, fail}, 3'b001);
            done = 1;
         end
         a++;
      end
      tick();
      check("end_idle", {busy, st}, 0);
      check("n_call", 256'(n_call - c_call), 256'(v.exp_calls));
      check("n_suc", 256'(n_suc - c_suc), 256'(v.exp_suc));
      check("n_pass", 256'(n_pass - c_pass), 256'(v.exp_pass));
      check("n_fail", 256'(n_fail - c_fail), 256'(v.exp_fail));
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      int n, cyc, c_suc, c_fail, c_pass;
      logic [255:0] eb;
      tbl[0] = '{0, 0, 1, 0, 1, 1};
      tbl[1] = '{0, 1, 1, 0, 1, 1};
      tbl[2] = '{2, 0, 1, 0, 3, 1};
      tbl[3] = '{3, 0, 0, 1, 3, 0};
      tbl[4] = '{1, 1, 1, 0, 2, 1};
      tick();
      check("reset_ctrl", {rx_ready, tx_valid, core_call, core_suc, pass, fail, busy, st}, 0);
      check("reset_data", {tx_data, core_alpha[223:0]}, 0);
      rst_n = 1;
      tick();
      check("idle_after_reset", {busy, st, rx_ready}, 0);
      for (int r = 0; r < 5; r++) run_row(r);
      check("tx_stable_stall", 256'(stall_bad), 0);
      // timeout: four words then silence
      c_suc = n_suc; c_fail = n_fail;
      start = 1; tick(); start = 0;
      send_alpha(7, 4, 0, cyc);
      n = 0;
      while (st != 3'd7 && n < 40) begin
         tick();
         n++;
      end
      check("timeout_cycles", 256'(n), 16);
      check("timeout_fail", 256'(fail), 1);
      tick();
      check("timeout_idle", 256'(st), 0);
      start = 1; tick(); start = 0;
      check("restart_rx_ready", 256'(rx_ready), 1);
      n = 0;
      while (st != 3'd0 && n < 40) begin
         tick();
         n++;
      end
      check("second_timeout_idle", 256'(st), 0);
      check("timeout_no_suc", 256'(n_suc - c_suc), 0);
      check("timeout_fail_count", 256'(n_fail - c_fail), 2);
      // reset while streaming beta
      start = 1; tick(); start = 0;
      send_alpha(0, 8, 0, cyc);
      tick();
      for (int k = 0; k < 8; k++) eb[k*32 +: 32] = 32'hC0DE0000 + 32'(k);
      core_done = 1; core_beta = eb;
      tick();
      core_done = 0;
      check("in_tx_beta", {st, tx_data}, {3'd4, 32'hC0DE0000});
      tick();
      c_pass = n_pass; c_fail = n_fail;
      #2 rst_n = 0;
      #1;
      check("async_reset_ctrl", {rx_ready, tx_valid, core_call, core_suc, pass, fail, busy, st}, 0);
      check("async_reset_data", {tx_data, core_alpha[223:0]}, 0);
      check("async_reset_alpha_hi", core_alpha, 0);
      tick();
      rst_n = 1;
      tick();
      check("reset_no_pulse", {32'(n_pass - c_pass), 32'(n_fail - c_fail)}, 0);
      run_row(0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
